// File: rtl/fifo_pkt_streamer_if.sv
// Framed valid/ready stream carrying FIFO words to the packet fabric.
// STREAM_PARITY_EN adds an even-parity bit alongside the data.
interface fifo_pkt_streamer_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
`ifdef STREAM_PARITY_EN
   logic                  m_parity;

   modport master (output m_valid, output m_data, output m_last, output m_parity, input m_ready);
   modport slave  (input m_valid, input m_data, input m_last, input m_parity, output m_ready);
`else
   modport master (output m_valid, output m_data, output m_last, input m_ready);
   modport slave  (input m_valid, input m_data, input m_last, output m_ready);
`endif
endinterface

// File: rtl/fifo_pkt_streamer.sv
// Drains a synchronous FIFO into a framed valid/ready stream. Pops are
// credit-limited so the small buffer absorbing the FIFO's one-cycle read
// latency can never overflow; every PKT_LEN-th beat carries m_last.
// Optional feature macro: STREAM_PARITY_EN (adds m_parity to the stream).
module fifo_pkt_streamer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned PKT_LEN    = 16,
   parameter int unsigned BUF_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fifo_empty,
   output logic                  fifo_rd,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   fifo_pkt_streamer_if.master   m,
   output logic [15:0]           pkt_count,
   output logic                  busy
);

   localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam int unsigned IDX_W = 16;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
   localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(BUF_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, FINISH, DRAIN} state_t;

   state_t                state_q;
   logic                  busy_q;
   logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [OCC_W-1:0]      occ_q;
   logic [OCC_W-1:0]      occ_d;
   logic                  inflight_q;
   logic [IDX_W-1:0]      rd_idx_q;
   logic [IDX_W-1:0]      rd_idx_d;
   logic [IDX_W-1:0]      beat_idx_q;
   logic [IDX_W-1:0]      beat_idx_d;
   logic [15:0]           pkt_count_q;
   logic [15:0]           pkt_count_d;

   logic                  fifo_rd_c;
   logic                  rd_wrap_c;
   logic                  m_valid_c;
   logic                  m_last_c;
   logic                  hs_c;
   logic [DATA_WIDTH-1:0] head_c;

   // Pop only while credits remain; deliberately independent of m_ready
   assign fifo_rd_c = ((state_q == RUN) || (state_q == FINISH)) && !fifo_empty &&
                      ((occ_q + OCC_W'(inflight_q)) < DEPTH_C);
   assign rd_wrap_c = fifo_rd_c && (rd_idx_q == LAST_IDX);

   assign head_c    = buf_q[rd_ptr_q];
   assign m_valid_c = (occ_q != '0);
   assign m_last_c  = m_valid_c && (beat_idx_q == LAST_IDX);
   assign hs_c      = m_valid_c && m.m_ready;

   assign fifo_rd   = fifo_rd_c;
   assign m.m_valid = m_valid_c;
   assign m.m_data  = head_c;
   assign m.m_last  = m_last_c;
   assign pkt_count = pkt_count_q;
   assign busy      = busy_q;
`ifdef STREAM_PARITY_EN
   assign m.m_parity = ^head_c;
`endif

   // Next values for occupancy and the packet/beat counters
   always_comb begin
      occ_d       = occ_q;
      rd_idx_d    = rd_idx_q;
      beat_idx_d  = beat_idx_q;
      pkt_count_d = pkt_count_q;
      if (fifo_rd_c) begin
         rd_idx_d = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + IDX_W'(1);
      end
      if (hs_c) begin
         beat_idx_d = (beat_idx_q == LAST_IDX) ? '0 : beat_idx_q + IDX_W'(1);
         if (m_last_c) begin
            pkt_count_d = pkt_count_q + 16'(1);
         end
      end
      case ({inflight_q, hs_c})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Buffer storage: capture returning FIFO data at the tail
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            buf_q[i] <= '0;
         end
      end else if (inflight_q) begin
         buf_q[wr_ptr_q] <= fifo_rdata;
      end
   end

   // Pointers, credits and framing counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         inflight_q  <= 1'b0;
         rd_idx_q    <= '0;
         beat_idx_q  <= '0;
         pkt_count_q <= '0;
      end else begin
         inflight_q  <= fifo_rd_c;
         occ_q       <= occ_d;
         rd_idx_q    <= rd_idx_d;
         beat_idx_q  <= beat_idx_d;
         pkt_count_q <= pkt_count_d;
         if (inflight_q) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (hs_c) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   // Control FSM; stopping is deferred until the current packet's pops finish
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (enable) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               if (!enable) begin
                  state_q <= (rd_idx_d == '0) ? DRAIN : FINISH;
               end
            end
            FINISH: begin
               if (rd_wrap_c) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (enable) begin
                  state_q <= RUN;
               end else if ((occ_q == '0) && !inflight_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_pkt_streamer.sv
// Bench for fifo_pkt_streamer: behavioural FIFO on the read side and a
// scoreboard of expected {data,last} beats checked at every handshake.
// Define STREAM_PARITY_EN for both RTL and bench to exercise m_parity.
module tb_fifo_pkt_streamer;

   localparam int unsigned DW = 32;
   localparam int          PL = 4;
   localparam int unsigned BD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          fifo_empty;
   logic          fifo_rd;
   logic [DW-1:0] fifo_rdata;
   logic [15:0]   pkt_count;
   logic          busy;

   fifo_pkt_streamer_if #(.DATA_WIDTH(DW)) m_if ();

   fifo_pkt_streamer #(.DATA_WIDTH(DW), .PKT_LEN(PL), .BUF_DEPTH(BD)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .fifo_rdata (fifo_rdata),
      .m          (m_if),
      .pkt_count  (pkt_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Behavioural synchronous FIFO: data appears the cycle after a pop
   logic [DW-1:0] fifo_mem [64];
   int            wp;
   int            rp;
   assign fifo_empty = (rp == wp);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         rp         <= 0;
         fifo_rdata <= '0;
      end else if (fifo_rd) begin
         fifo_rdata <= fifo_mem[rp];
         rp         <= rp + 1;
      end
   end

   int            checks;
   int            errors;
   int            exp_cnt;
   logic [DW:0]   sb [$];

   // Load one word into the FIFO; optionally record it as an expected beat
   task automatic push_word(input logic [DW-1:0] w, input bit expect_out);
      logic l;
      fifo_mem[wp] = w;
      wp = wp + 1;
      if (expect_out) begin
         l = ((exp_cnt % PL) == (PL - 1));
         sb.push_back({w, l});
         exp_cnt = exp_cnt + 1;
      end
   endtask

   // Advance one cycle; the scoreboard consumes any handshake seen mid-cycle
   task automatic step();
      logic [DW:0] e;
      @(negedge clk);
      if (reset && m_if.m_valid && m_if.m_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_beat: got unexpected beat data=%h last=%b, expected no beat",
                     m_if.m_data, m_if.m_last);
         end else begin
            e = sb.pop_front();
            if ({m_if.m_data, m_if.m_last} !== e) begin
               errors++;
               $display("FAIL sb_beat: got data=%h last=%b, expected data=%h last=%b",
                        m_if.m_data, m_if.m_last, e[DW:1], e[0]);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      enable = 1'b0;
      m_if.m_ready = 1'b0;
      wp = 0;
      sb.delete();
      exp_cnt = 0;
      repeat (2) step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      enable = 1'b0;
      m_if.m_ready = 1'b0;
      wp = 0;
      repeat (2) step();
      checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd: got %b expected 0", fifo_rd); end
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_if.m_valid); end
      checks++; if (m_if.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b expected 0", m_if.m_last); end
      checks++; if (m_if.m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h expected 0", m_if.m_data); end
      checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      reset = 1'b1;
      step();
   endtask

   task automatic test_stream();
      logic exp_v;
      apply_reset();
      for (int i = 1; i <= 8; i++) push_word(DW'(i), 1'b1);
      enable = 1'b1;
      m_if.m_ready = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         step();
         exp_v = (c >= 3) && (c <= 10);
         checks++;
         if (m_if.m_valid !== exp_v) begin
            errors++;
            $display("FAIL stream_valid_c%0d: got %b expected %b", c, m_if.m_valid, exp_v);
         end
         if (c == 3) begin
            checks++;
            if (m_if.m_data !== 32'h1) begin errors++; $display("FAIL stream_first_data: got %h expected 1", m_if.m_data); end
         end
      end
      checks++; if (pkt_count !== 16'd2) begin errors++; $display("FAIL stream_pkt_count: got %0d expected 2", pkt_count); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL stream_left: got %0d beats pending expected 0", sb.size()); end
      enable = 1'b0;
      repeat (4) step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_idle: got busy %b expected 0", busy); end
   endtask

   task automatic test_backpressure();
      int pops;
      apply_reset();
      for (int i = 1; i <= 8; i++) push_word(DW'(i), 1'b1);
      enable = 1'b1;
      m_if.m_ready = 1'b0;
      pops = 0;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (fifo_rd) pops++;
         if (c >= 3) begin
            checks++;
            if (m_if.m_valid !== 1'b1 || m_if.m_data !== 32'h1) begin
               errors++;
               $display("FAIL bp_hold_c%0d: got valid=%b data=%h expected valid=1 data=1", c, m_if.m_valid, m_if.m_data);
            end
         end
      end
      checks++; if (pops != 4) begin errors++; $display("FAIL bp_pops: got %0d expected 4", pops); end
      checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL bp_rd_hold: got %b expected 0", fifo_rd); end
      m_if.m_ready = 1'b1;
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
         step();
         if (fifo_rd) pops++;
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d beats pending expected 0", sb.size()); end
      checks++; if (pops != 8) begin errors++; $display("FAIL bp_total_pops: got %0d expected 8", pops); end
      checks++; if (pkt_count !== 16'd2) begin errors++; $display("FAIL bp_pkt_count: got %0d expected 2", pkt_count); end
   endtask

   task automatic test_stop_mid_packet();
      int pops;
      apply_reset();
      for (int i = 1; i <= 8; i++) push_word(DW'(i), i <= 4);
      enable = 1'b1;
      m_if.m_ready = 1'b1;
      pops = 0;
      for (int c = 1; c <= 14; c++) begin
         step();
         if (fifo_rd) pops++;
         if (c == 3) enable = 1'b0;
         if (c == 7) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL stop_busy_c7: got %b expected 1", busy); end
         end
         if (c == 8) begin
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy_c8: got %b expected 0", busy); end
         end
      end
      checks++; if (pops != 4) begin errors++; $display("FAIL stop_pops: got %0d expected 4", pops); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL stop_drain: got %0d beats pending expected 0", sb.size()); end
      checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL stop_pkt_count: got %0d expected 1", pkt_count); end
   endtask

   task automatic test_underflow();
      apply_reset();
      push_word(32'hB1, 1'b1);
      push_word(32'hB2, 1'b1);
      enable = 1'b1;
      m_if.m_ready = 1'b1;
      repeat (10) step();
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL uf_stall_valid: got %b expected 0", m_if.m_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL uf_stall_busy: got %b expected 1", busy); end
      repeat (10) step();
      push_word(32'hB3, 1'b1);
      push_word(32'hB4, 1'b1);
      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL uf_drain: got %0d beats pending expected 0", sb.size()); end
      step();
      checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL uf_pkt_count: got %0d expected 1", pkt_count); end
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL uf_no_pad: got valid %b expected 0", m_if.m_valid); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 1; i <= 8; i++) push_word(DW'(i), 1'b0);
      enable = 1'b1;
      m_if.m_ready = 1'b0;
      repeat (5) step();
      checks++; if (m_if.m_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b expected 1", m_if.m_valid); end
      reset = 1'b0;
      #1;
      checks++; if (m_if.m_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", m_if.m_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
      checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL rm_pkt_count: got %0d expected 0", pkt_count); end
      checks++; if (m_if.m_data !== '0) begin errors++; $display("FAIL rm_data: got %h expected 0", m_if.m_data); end
      enable = 1'b0;
      wp = 0;
      sb.delete();
      exp_cnt = 0;
      repeat (2) step();
      reset = 1'b1;
      step();
      for (int i = 0; i < 4; i++) push_word(32'hA1 + DW'(i), 1'b1);
      enable = 1'b1;
      m_if.m_ready = 1'b1;
      for (int i = 0; i < 30 && sb.size() != 0; i++) step();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL rm_drain: got %0d beats pending expected 0", sb.size()); end
      step();
      checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL rm_pkt_count_after: got %0d expected 1", pkt_count); end
   endtask

`ifdef STREAM_PARITY_EN
   task automatic test_parity();
      apply_reset();
      push_word(32'h7, 1'b1);
      push_word(32'h3, 1'b1);
      push_word(32'h5, 1'b1);
      push_word(32'h6, 1'b1);
      enable = 1'b1;
      m_if.m_ready = 1'b0;
      for (int i = 0; i < 10 && !m_if.m_valid; i++) step();
      step();
      checks++;
      if (m_if.m_data !== 32'h7 || m_if.m_parity !== 1'b1) begin
         errors++;
         $display("FAIL parity_7: got data=%h parity=%b expected data=7 parity=1", m_if.m_data, m_if.m_parity);
      end
      m_if.m_ready = 1'b1;
      step();
      m_if.m_ready = 1'b0;
      checks++;
      if (m_if.m_data !== 32'h3 || m_if.m_parity !== 1'b0) begin
         errors++;
         $display("FAIL parity_3: got data=%h parity=%b expected data=3 parity=0", m_if.m_data, m_if.m_parity);
      end
      m_if.m_ready = 1'b1;
      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL parity_drain: got %0d beats pending expected 0", sb.size()); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      exp_cnt = 0;
      wp = 0;
      reset = 1'b0;
      enable = 1'b0;
      m_if.m_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_stop_mid_packet();
      test_underflow();
      test_reset_mid();
`ifdef STREAM_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
